fsm_seq_stim_gen: RTL

- Transmit-side counterpart of the two-input sequence-detector FSM.
- Drives the fixed 11-event {i2,i1} stimulus sequence that walks the detector from s1 to s12, with the team's standard relative step timing.
- Used in-fabric or in benches to exercise the detector; supports timed (auto) and externally stepped (manual) modes, plus start/busy/done/abort control.

---
 rtl/fsm_seq_stim_gen_if.sv | 23 ++
 rtl/fsm_seq_stim_gen.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fsm_seq_stim_gen_if.sv
// Control and stimulus bundle between a sequence-detector stimulus generator
// and whatever drives it (fabric controller or testbench).
interface fsm_seq_stim_gen_if;
   logic       start;
   logic       manual;
   logic       step_req;
   logic       abort;
   logic       i2;
   logic       i1;
   logic [3:0] step_idx;
   logic       busy;
   logic       done;

   modport master (
      output start, manual, step_req, abort,
      input  i2, i1, step_idx, busy, done
   );

   modport slave (
      input  start, manual, step_req, abort,
      output i2, i1, step_idx, busy, done
   );
endinterface

// File: rtl/fsm_seq_stim_gen.sv
// Drives the 11-event {i2,i1} walk that takes the two-input sequence detector
// from s1 to s12, either self-timed (weight*HOLD_UNIT cycles per step) or stepped.
module fsm_seq_stim_gen #(
   parameter int HOLD_UNIT = 4,
   parameter int CNT_W     = 12
) (
   input  logic              clk,
   input  logic              reset,
   fsm_seq_stim_gen_if.slave bus
);

   localparam logic [3:0] LAST_STEP = 4'd11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   typedef struct packed {
      logic [1:0] pat;
      logic [2:0] weight;
   } step_t;

   // NOTE: the step table is a constant case lookup, not storage, so there is
   // nothing here that needs a reset value.
   function automatic step_t step_entry(input logic [3:0] idx);
      case (idx)
         4'd1:    step_entry = '{pat: 2'b01, weight: 3'd5};
         4'd2:    step_entry = '{pat: 2'b11, weight: 3'd5};
         4'd3:    step_entry = '{pat: 2'b10, weight: 3'd5};
         4'd4:    step_entry = '{pat: 2'b00, weight: 3'd5};
         4'd5:    step_entry = '{pat: 2'b01, weight: 3'd3};
         4'd6:    step_entry = '{pat: 2'b11, weight: 3'd5};
         4'd7:    step_entry = '{pat: 2'b10, weight: 3'd2};
         4'd8:    step_entry = '{pat: 2'b00, weight: 3'd3};
         4'd9:    step_entry = '{pat: 2'b10, weight: 3'd2};
         4'd10:   step_entry = '{pat: 2'b11, weight: 3'd5};
         4'd11:   step_entry = '{pat: 2'b10, weight: 3'd5};
         default: step_entry = '{pat: 2'b00, weight: 3'd0};
      endcase
   endfunction

   // Counter counts down to zero, so a step lasting N cycles loads N-1.
   function automatic logic [CNT_W-1:0] hold_load(input logic [3:0] idx);
      hold_load = CNT_W'(int'(step_entry(idx).weight) * HOLD_UNIT - 1);
   endfunction

   state_t           state_q,  state_d;
   logic [3:0]       idx_q,    idx_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic             manual_q, manual_d;
   logic [1:0]       pat_q,    pat_d;
   logic             busy_q,   busy_d;
   logic             done_q,   done_d;
   logic             advance;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values computed by the combinational block.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         idx_q    <= 4'd0;
         cnt_q    <= '0;
         manual_q <= 1'b0;
         pat_q    <= 2'b00;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         manual_q <= manual_d;
         pat_q    <= pat_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // NOTE: every signal gets a default before the case so no path leaves a
   // value unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      manual_d = manual_q;
      pat_d    = pat_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      advance  = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               state_d  = RUN;
               idx_d    = 4'd1;
               pat_d    = step_entry(4'd1).pat;
               cnt_d    = hold_load(4'd1);
               manual_d = bus.manual;
               busy_d   = 1'b1;
            end
         end

         RUN: begin
            if (bus.abort) begin
               // Abort wins over both a step request and a timer expiry.
               state_d = IDLE;
               idx_d   = 4'd0;
               pat_d   = 2'b00;
               cnt_d   = '0;
               busy_d  = 1'b0;
            end else begin
               advance = manual_q ? bus.step_req : (cnt_q == '0);
               if (!manual_q && cnt_q != '0) begin
                  cnt_d = cnt_q - 1'b1;
               end
               if (advance) begin
                  if (idx_q == LAST_STEP) begin
                     state_d = FIN;
                     idx_d   = 4'd0;
                     pat_d   = 2'b00;
                     cnt_d   = '0;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     idx_d = idx_q + 4'd1;
                     pat_d = step_entry(idx_q + 4'd1).pat;
                     cnt_d = hold_load(idx_q + 4'd1);
                  end
               end
            end
         end

         FIN: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            idx_d   = 4'd0;
            pat_d   = 2'b00;
            cnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign bus.i2       = pat_q[1];
   assign bus.i1       = pat_q[0];
   assign bus.step_idx = idx_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

endmodule
